// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and state encoding for the segment scanner
// Contents: BCD/segment widths, blank pattern, largest valid BCD digit,
//           scan FSM state constants and a BCD range helper.
package seg_scan_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b0;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BLANK = 2'd1;
  localparam state_t ST_SHOW  = 2'd2;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - valid/ready load port carrying a full display word
// Signals: load_valid (producer offers word), load_ready (controller can accept),
//          load_data (nibble k = digit k, digit 0 in bits [3:0]).
// Modports: master = value producer, slave = scan controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_scan_pkg::*;

  logic                        load_valid;
  logic                        load_ready;
  logic [BCD_W*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - loadable down-counter with terminal count
// Ports: clk, rst_n (async active-low), load/load_val (start a new interval),
//        tc (high while the count is zero, i.e. last cycle of the interval).
module seg_scan_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with double-buffered word
// Ports: clk, rst_n (async active-low), enable (scan on), load (slave load port),
//        bcd_out (nibble to shared decoder), seg_in (decoder output, index 0 = a),
//        seg_out (registered segments), dig_en (one-hot digit enable),
//        frame_done (high during the last cycle of the last digit's SHOW).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        load,
  output logic [BCD_W-1:0]      bcd_out,
  input  logic [SEG_W-1:0]      seg_in,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done
);

  localparam int WORD_W  = BCD_W * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  active_q, active_d;
  logic [WORD_W-1:0]  shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_tc;
  logic               frame_end;

  seg_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Frame boundary: last SHOW cycle of the last digit with scanning still on.
  assign frame_end = (state_q == ST_SHOW) && enable && tmr_tc && (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    tmr_load  = 1'b0;
    tmr_val   = BLANK_LD;

    // Handshake and copy never coincide: one needs pending low, the other high.
    if (load.load_valid && !pending_q) begin
      shadow_d  = load.load_data;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        seg_d = SEG_OFF;
        idx_d = '0;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
        if (enable) begin
          state_d  = ST_BLANK;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LD;
          bcd_d    = active_d[BCD_W-1:0];
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          seg_d   = SEG_OFF;
          idx_d   = '0;
        end else begin
          // Keep sampling the decoder; the last BLANK cycle's value is what SHOW holds.
          seg_d = bcd_valid(bcd_q) ? seg_in : SEG_OFF;
          if (tmr_tc) begin
            state_d  = ST_SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
          end
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          seg_d   = SEG_OFF;
          idx_d   = '0;
        end else if (tmr_tc) begin
          state_d  = ST_BLANK;
          tmr_load = 1'b1;
          tmr_val  = BLANK_LD;
          if (frame_end) begin
            idx_d = '0;
            if (pending_q) begin
              active_d  = shadow_q;
              pending_d = 1'b0;
            end
            bcd_d = active_d[BCD_W-1:0];
          end else begin
            idx_d = idx_q + 1'b1;
            bcd_d = active_q[BCD_W*idx_d +: BCD_W];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        seg_d   = SEG_OFF;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= '0;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      seg_q     <= seg_d;
    end
  end

  assign load.load_ready = !pending_q;
  assign bcd_out         = bcd_q;
  assign seg_out         = seg_q;
  assign dig_en          = (state_q == ST_SHOW) ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign frame_done      = frame_end;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = PS + BC;
  localparam int FRAME = ND * SLOT;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] bcd_out;
  logic [6:0] seg_in;
  logic [6:0] seg_out;
  logic [3:0] dig_en;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) load_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load_if),
    .bcd_out    (bcd_out),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared decoder; invalid codes give junk that must be ignored.
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'h55;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    return (n > 4'd9) ? 7'd0 : dec(n);
  endfunction

  assign seg_in = dec(bcd_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scanning position is a frame-relative cycle number.
  logic        m_run  = 1'b0;
  int          m_t    = 0;
  logic [15:0] m_act  = 16'h0;
  logic [15:0] m_sh   = 16'h0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_bcd  = 4'h0;
  logic        m_hs;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0; m_t = 0; m_act = '0; m_sh = '0; m_pend = 1'b0; m_bcd = '0;
      end else begin
        m_hs = load_if.load_valid && !m_pend;
        if (!m_run) begin
          if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
          if (enable) begin m_run = 1'b1; m_t = 0; m_bcd = m_act[3:0]; end
        end else if (!enable) begin
          m_run = 1'b0;
        end else if (m_t == FRAME - 1) begin
          if (m_pend) begin m_act = m_sh; m_pend = 1'b0; end
          m_t = 0;
          m_bcd = m_act[3:0];
        end else begin
          m_t++;
          if (m_t % SLOT == 0) m_bcd = m_act[4*(m_t/SLOT) +: 4];
        end
        if (m_hs) begin m_sh = load_if.load_data; m_pend = 1'b1; end
      end
    end
  end

  int         c_slot, c_dig;
  logic [3:0] c_den;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      c_slot = m_t % SLOT;
      c_dig  = m_t / SLOT;
      c_den  = (m_run && c_slot >= BC) ? 4'(1 << c_dig) : 4'd0;
      chk("m_load_ready", {31'd0, load_if.load_ready}, {31'd0, !m_pend});
      chk("m_dig_en", {28'd0, dig_en}, {28'd0, c_den});
      chk("m_frame_done", {31'd0, frame_done}, {31'd0, m_run && m_t == FRAME - 1 && enable});
      chk("m_bcd_out", {28'd0, bcd_out}, {28'd0, m_bcd});
      if (!m_run)
        chk("m_seg_idle", {25'd0, seg_out}, 32'd0);
      else if (c_slot >= BC)
        chk("m_seg_show", {25'd0, seg_out}, {25'd0, exp_seg(m_act[4*c_dig +: 4])});
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_dig(input logic [3:0] want);
    int n;
    n = 0;
    while (dig_en == want && n < 100) begin tick(); n++; end
    while (dig_en != want && n < 200) begin tick(); n++; end
    chk("wait_dig", {28'd0, dig_en}, {28'd0, want});
  endtask

  task automatic wait_fd;
    int n;
    n = 0;
    tick();
    while (frame_done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("wait_frame_done", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic load_word(input logic [15:0] w);
    load_if.load_valid = 1'b1;
    load_if.load_data  = w;
    tick();
    load_if.load_valid = 1'b0;
  endtask

  int c1, c2, n;

  initial begin
    load_if.load_valid = 1'b0;
    load_if.load_data  = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, load_if.load_ready}, 32'd1);
    chk("rst_dig_en", {28'd0, dig_en}, 32'd0);
    chk("rst_seg", {25'd0, seg_out}, 32'd0);
    chk("rst_bcd", {28'd0, bcd_out}, 32'd0);

    // Load while idle, then scan 4321.
    load_word(16'h4321);
    chk("idle_load_ready0", {31'd0, load_if.load_ready}, 32'd0);
    tick();
    chk("idle_copy_ready1", {31'd0, load_if.load_ready}, 32'd1);
    enable = 1'b1;
    wait_dig(4'b0001); chk("d0_is_1", {25'd0, seg_out}, 32'b0000110);
    wait_dig(4'b0010); chk("d1_is_2", {25'd0, seg_out}, 32'b1011011);
    wait_dig(4'b0100); chk("d2_is_3", {25'd0, seg_out}, 32'b1001111);
    wait_dig(4'b1000); chk("d3_is_4", {25'd0, seg_out}, 32'b1100110);
    wait_fd(); c1 = cyc;
    wait_fd(); c2 = cyc;
    chk("frame_period", c2 - c1, 32'd24);

    // Mid-frame load must not tear the current frame.
    wait_dig(4'b0010);
    load_word(16'h9999);
    chk("mid_ready0", {31'd0, load_if.load_ready}, 32'd0);
    wait_dig(4'b0100); chk("mid_d2_still_3", {25'd0, seg_out}, 32'b1001111);
    wait_dig(4'b1000); chk("mid_d3_still_4", {25'd0, seg_out}, 32'b1100110);
    wait_fd();
    chk("fd_ready_still0", {31'd0, load_if.load_ready}, 32'd0);
    tick();
    chk("after_fd_ready1", {31'd0, load_if.load_ready}, 32'd1);
    wait_dig(4'b0001); chk("nines_d0", {25'd0, seg_out}, 32'b1101111);

    // Invalid BCD nibbles blank their digit.
    load_word(16'hA0F5);
    wait_fd();
    wait_dig(4'b0001); chk("a0f5_d0_5", {25'd0, seg_out}, 32'b1101101);
    wait_dig(4'b0010); chk("a0f5_d1_blank", {25'd0, seg_out}, 32'd0);
    wait_dig(4'b0100); chk("a0f5_d2_0", {25'd0, seg_out}, 32'b0111111);
    wait_dig(4'b1000); chk("a0f5_d3_blank", {25'd0, seg_out}, 32'd0);

    // Disable during digit 2, then restart.
    wait_dig(4'b0100);
    enable = 1'b0;
    tick();
    chk("dis_dig_en", {28'd0, dig_en}, 32'd0);
    chk("dis_seg", {25'd0, seg_out}, 32'd0);
    enable = 1'b1;
    n = 0;
    do begin tick(); n++; end while (dig_en != 4'b0001 && n < 50);
    chk("restart_latency", n, 32'd3);

    // Load offered on the frame_done cycle while pending.
    load_word(16'h1111);
    chk("p_ready0", {31'd0, load_if.load_ready}, 32'd0);
    wait_fd();
    chk("fd_cycle_ready0", {31'd0, load_if.load_ready}, 32'd0);
    load_if.load_valid = 1'b1;
    load_if.load_data  = 16'h7777;
    tick();
    chk("fd_next_ready1", {31'd0, load_if.load_ready}, 32'd1);
    tick();
    load_if.load_valid = 1'b0;
    chk("fd_accepted", {31'd0, load_if.load_ready}, 32'd0);
    wait_dig(4'b0001); chk("ones_shown", {25'd0, seg_out}, 32'b0000110);
    wait_fd();
    wait_dig(4'b0001); chk("sevens_shown", {25'd0, seg_out}, 32'b0000111);

    // Asynchronous reset mid-cycle while pending and lit.
    load_word(16'h8888);
    chk("pre_rst_ready0", {31'd0, load_if.load_ready}, 32'd0);
    wait_dig(4'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_dig_en", {28'd0, dig_en}, 32'd0);
    chk("arst_seg", {25'd0, seg_out}, 32'd0);
    chk("arst_ready", {31'd0, load_if.load_ready}, 32'd1);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = !enable;
      load_if.load_valid = ($urandom_range(0, 9) == 0);
      load_if.load_data  = 16'($urandom);
      tick();
    end
    load_if.load_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
